// File: rtl/kb_edit_ctrl.sv
// kb_edit_ctrl: turns PS/2 set-2 scan-code pulses into character RAM writes
// and cursor moves (typing, backspace, enter, arrows, Esc screen clear).
// The cursor is kept both as a linear cell address and as row/col so that
// Enter and the vertical arrows need no divider.
module kb_edit_ctrl #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        scan_code,
  input  logic              scan_code_ready,
  input  logic [7:0]        ascii_in,
  input  logic              letter_case,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy
);

  localparam int N     = COLS * ROWS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(ROWS - 1);

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SPACE    = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK,
    S_CLEAR
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic [ADDR_W-1:0] cursor_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [COL_W-1:0]  col, col_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;

  // Lowercase letters become uppercase when the keyboard reports shift/caps.
  function automatic logic [7:0] apply_case(input logic [7:0] a, input logic upper);
    if (upper && (a >= 8'h61) && (a <= 8'h7A)) return a - 8'h20;
    return a;
  endfunction

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    cursor_n  = cursor;
    row_n     = row;
    col_n     = col;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;

    case (state)
      S_CLEAR: begin
        // Incoming pulses are ignored for the whole sweep.
        wr_en_n   = 1'b1;
        wr_addr_n = clr_cnt;
        wr_data_n = SPACE;
        cursor_n  = '0;
        row_n     = '0;
        col_n     = '0;
        if (clr_cnt == LAST_A) begin
          state_n   = S_IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end

      S_IDLE: begin
        if (scan_code_ready) begin
          if (scan_code == SC_BRK) begin
            state_n = S_BRK;
          end else if (scan_code == SC_EXT) begin
            state_n = S_EXT;
          end else if (scan_code == SC_ESC) begin
            // Address 0 is written right away so the sweep starts next cycle.
            state_n   = S_CLEAR;
            wr_en_n   = 1'b1;
            wr_addr_n = '0;
            wr_data_n = SPACE;
            clr_cnt_n = ADDR_W'(1);
            cursor_n  = '0;
            row_n     = '0;
            col_n     = '0;
          end else if (scan_code == SC_BKSP) begin
            if (cursor != '0) begin
              cursor_n  = cursor - 1'b1;
              wr_en_n   = 1'b1;
              wr_addr_n = cursor - 1'b1;
              wr_data_n = SPACE;
              if (col == '0) begin
                col_n = COL_MAX;
                row_n = row - 1'b1;
              end else begin
                col_n = col - 1'b1;
              end
            end
          end else if (scan_code == SC_ENTER) begin
            col_n = '0;
            if (row == ROW_MAX) begin
              row_n    = '0;
              cursor_n = '0;
            end else begin
              row_n    = row + 1'b1;
              cursor_n = cursor - ADDR_W'(col) + COLS_A;
            end
          end else if ((ascii_in >= 8'h20) && (ascii_in <= 8'h7E)) begin
            wr_en_n   = 1'b1;
            wr_addr_n = cursor;
            wr_data_n = apply_case(ascii_in, letter_case);
            if (cursor == LAST_A) begin
              cursor_n = '0;
              row_n    = '0;
              col_n    = '0;
            end else begin
              cursor_n = cursor + 1'b1;
              if (col == COL_MAX) begin
                col_n = '0;
                row_n = row + 1'b1;
              end else begin
                col_n = col + 1'b1;
              end
            end
          end
        end
      end

      S_EXT: begin
        if (scan_code_ready) begin
          state_n = S_IDLE;
          if (scan_code == SC_BRK) begin
            state_n = S_EXT_BRK;
          end else if (scan_code == SC_LEFT) begin
            if (cursor != '0) begin
              cursor_n = cursor - 1'b1;
              if (col == '0) begin
                col_n = COL_MAX;
                row_n = row - 1'b1;
              end else begin
                col_n = col - 1'b1;
              end
            end
          end else if (scan_code == SC_RIGHT) begin
            if (cursor != LAST_A) begin
              cursor_n = cursor + 1'b1;
              if (col == COL_MAX) begin
                col_n = '0;
                row_n = row + 1'b1;
              end else begin
                col_n = col + 1'b1;
              end
            end
          end else if (scan_code == SC_UP) begin
            if (row != '0) begin
              row_n    = row - 1'b1;
              cursor_n = cursor - COLS_A;
            end
          end else if (scan_code == SC_DOWN) begin
            if (row != ROW_MAX) begin
              row_n    = row + 1'b1;
              cursor_n = cursor + COLS_A;
            end
          end
        end
      end

      S_BRK, S_EXT_BRK: begin
        if (scan_code_ready) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset re-enters the clear sweep from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      cursor  <= '0;
      row     <= '0;
      col     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= SPACE;
      busy    <= 1'b1;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      cursor  <= cursor_n;
      row     <= row_n;
      col     <= col_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      // Stays high through the cycle carrying the last sweep write.
      busy    <= (state == S_CLEAR) || (state_n == S_CLEAR);
    end
  end

endmodule

// File: doc/kb_edit_ctrl.md
# kb_edit_ctrl

Keyboard-to-text-buffer edit controller for the notepad. It consumes PS/2 set-2 scan-code pulses from `keyboard` and the matching ASCII from `translate_to_ASCII`, and decodes make, break and extended prefixes. It then sequences writes into the character RAM and maintains the cursor (typing, backspace, enter, arrows, screen clear). It sits between the keyboard front end and the display character memory.

## Interface
- `COLS`, default 40: characters per row.
- `ROWS`, default 30: rows per screen.
- `ADDR_W`, default 11: width of the cell address; must satisfy 2^ADDR_W ≥ COLS·ROWS.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  synchronous, active-high reset.
- `scan_code`  in  8  last scan byte from `keyboard`.
- `scan_code_ready`  in  1  one-cycle pulse; `scan_code` is valid in that cycle.
- `ascii_in`  in  8  translator output for `scan_code`. Letters are lowercase; unmapped codes give 0x00.
- `letter_case`  in  1  1 = uppercase (shift/caps state from `keyboard`).
- `wr_en`  out  1  character RAM write strobe, one cycle per write.
- `wr_addr`  out  ADDR_W  RAM cell address; cell = row·COLS + col.
- `wr_data`  out  8  ASCII byte to write.
- `cursor`  out  ADDR_W  current cursor cell.
- `busy`  out  1  high while a clear sweep runs.

## Operation
- N = COLS·ROWS. LAST = N−1.
- All outputs are registered.
- FSM states:
  - IDLE: waiting for a make code.
  - BRK: after 0xF0.
  - EXT: after 0xE0.
  - EXT_BRK: after 0xE0 0xF0.
  - CLEAR: clear sweep in progress.
- FSM transitions, evaluated only on `scan_code_ready`, except CLEAR:
  - IDLE + 0xF0 → BRK.
  - IDLE + 0xE0 → EXT.
  - IDLE + any other code → execute make action, stay in IDLE.
  - BRK + any code → IDLE, byte discarded (key release).
  - EXT + 0xF0 → EXT_BRK.
  - EXT + 0x6B/0x74/0x75/0x72 → left/right/up/down action, then IDLE.
  - EXT + any other code → IDLE, ignored.
  - EXT_BRK + any code → IDLE, discarded.
- Make actions in IDLE, checked in this priority order:
  - 0x76 Esc → enter CLEAR.
  - 0x66 Backspace:
    - cursor > 0 → cursor−1, write 0x20 at the new cursor.
    - cursor = 0 → no write, no move.
  - 0x5A Enter → cursor = (row+1)·COLS; from the last row, cursor = 0. No write.
  - `ascii_in` in 0x20..0x7E:
    - write at cursor, then cursor = cursor+1, wrapping LAST → 0.
    - if `letter_case`=1 and `ascii_in` is in 0x61..0x7A, `wr_data` = `ascii_in`−0x20.
  - Otherwise (0x00 or a control code) → ignored.
- Arrow actions (all saturating, no write):
  - left: cursor−1; no move at 0.
  - right: cursor+1; no move at LAST.
  - up: cursor−COLS; no move if cursor < COLS.
  - down: cursor+COLS; no move if cursor+COLS > LAST.
- CLEAR state:
  - one write per cycle: `wr_en`=1, `wr_addr` = 0,1,…,LAST, `wr_data`=0x20.
  - `cursor` is forced to 0 on entry.
  - after the write to LAST, return to IDLE.
  - `scan_code_ready` pulses during CLEAR are dropped; the prefix state is not retained.
- Reset:
  - sets the FSM to CLEAR with the sweep counter at 0, so every reset wipes the screen.
  - reset mid-sweep restarts the sweep from address 0.
  - reset mid-prefix (BRK/EXT) discards the prefix.

## Timing
- Reset values, held while `reset`=1:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0x20, `cursor`=0, `busy`=1.
- Reset sweep:
  - the first clock edge with `reset`=0 produces the write to address 0.
  - the addresses follow on N consecutive cycles.
  - `busy` falls on the edge after the write to LAST.
- Edit latency: `scan_code_ready` in cycle t:
  - `wr_en` high for exactly cycle t+1, with `wr_addr`/`wr_data` valid.
  - `cursor` holds its new value from t+1.
- Esc in cycle t:
  - `busy`=1 and `cursor`=0 from t+1.
  - writes in cycles t+1..t+N.
  - `busy`=0 at t+N+1.
- Typing: in t+1, `wr_addr` equals the pre-update cursor. Backspace: `wr_addr` equals the post-update cursor.
- `scan_code_ready` pulses are at least 2 cycles apart. Each pulse is fully handled before the next pulse.
- `wr_en` is never high outside CLEAR except in the single cycle after an accepted write action.

## Test plan
- Reset sweep: hold `reset` 3 cycles, then release → 1200 consecutive writes of 0x20 to addresses 0..1199; `busy` low afterwards; `cursor`=0.
- Typing with case and release:
  - stimulus: 0x1C ('a'), `letter_case`=0, then F0 1C, then 0x1C with `letter_case`=1.
  - required: write 0x61@0, then write 0x41@1; `cursor`=2; the F0 1C pair produces no write.
- Wrap and backspace:
  - wrap: set cursor=1199 via arrows, type 'b' → write 0x62@1199, `cursor`=0.
  - backspace at 0 → no write, `cursor`=0.
  - type 'c' then Backspace → write 0x20@0, `cursor`=0.
- Enter and arrows:
  - cursor=45, Enter → `cursor`=80.
  - E0 75 (up) → `cursor`=40.
  - from 0: E0 6B (left) → stays 0; E0 75 (up) → stays 0.
  - from 1170: E0 72 (down) → stays 1170.
  - E0 F0 74 → no movement.
- Esc mid-use:
  - cursor=300, Esc → 1200 clear writes, `cursor`=0 from t+1.
  - a 0x1C pulse injected during the sweep → dropped; no extra write after `busy` falls.
- Reset mid-sweep: assert `reset` at sweep address 500 → sweep restarts at 0 and completes all 1200 writes; `busy` stays high throughout.
